// File: rtl/mem_add_xfer_ctrl.sv
// Sequencer for the memory-to-memory add datapath: reads two operands, feeds the external adder, writes back the sum.
// Optional saturation on unsigned overflow is enabled by defining ADD_SAT_EN.
module mem_add_xfer_ctrl #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src1_base,
    input  logic [AW-1:0] src2_base,
    input  logic [AW-1:0] dst_base,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] DOut1,
    output logic [DW-1:0] DOut2,
    input  logic [DW-1:0] ADDOut,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, CAP, WR, DONE} state_t;

    state_t        state;
    logic [AW-1:0] i;
    logic [AW-1:0] i_nxt;
    logic [AW-1:0] s1;
    logic [AW-1:0] s2;
    logic [AW-1:0] d;
    logic [AW-1:0] n;
    logic          sat_c;
    logic [DW-1:0] wdata_c;

    assign i_nxt = i + AW'(1);

    // The adder output only settles once DOut2 is loaded, so write data follows ADDOut directly during WR.
`ifdef ADD_SAT_EN
    assign sat_c   = (ADDOut < DOut1);
    assign wdata_c = sat_c ? '1 : ADDOut;
`else
    assign sat_c   = 1'b0;
    assign wdata_c = ADDOut;
`endif

    assign mem_wdata = mem_wr ? wdata_c : '0;

    // State and all registered outputs advance together; outputs describe the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            i        <= '0;
            s1       <= '0;
            s2       <= '0;
            d        <= '0;
            n        <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            DOut1    <= '0;
            DOut2    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s1  <= src1_base;
                        s2  <= src2_base;
                        d   <= dst_base;
                        n   <= len;
                        i   <= '0;
                        ovf <= 1'b0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= RD1;
                            mem_rd   <= 1'b1;
                            mem_addr <= src1_base;
                            busy     <= 1'b1;
                        end
                    end
                end
                RD1: begin
                    state    <= RD2;
                    mem_rd   <= 1'b1;
                    mem_addr <= s2 + i;
                end
                RD2: begin
                    state <= CAP;
                    DOut1 <= mem_rdata;
                end
                CAP: begin
                    state    <= WR;
                    DOut2    <= mem_rdata;
                    mem_wr   <= 1'b1;
                    mem_addr <= d + i;
                end
                WR: begin
                    if (sat_c) begin
                        ovf <= 1'b1;
                    end
                    if (i == n - AW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        i        <= i_nxt;
                        state    <= RD1;
                        mem_rd   <= 1'b1;
                        mem_addr <= s1 + i_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_add_xfer_ctrl.sv
// Scoreboard bench for mem_add_xfer_ctrl: expected reads/writes are queued at issue time and
// checked by an independent monitor whenever the DUT strobes the memory.
module tb_mem_add_xfer_ctrl;

`ifdef ADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] src1_base;
    logic [3:0] src2_base;
    logic [3:0] dst_base;
    logic [3:0] len;
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] DOut1;
    logic [7:0] DOut2;
    logic [7:0] ADDOut;
    logic       busy;
    logic       done;
    logic       ovf;

    logic [7:0]  mem [16];
    logic [7:0]  exm [16];
    logic [3:0]  rdq [$];
    logic [11:0] wrq [$];
    logic [3:0]  e_ra;
    logic [11:0] e_w;

    int n_chk  = 0;
    int n_pass = 0;

    mem_add_xfer_ctrl #(.AW(4), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src1_base (src1_base),
        .src2_base (src2_base),
        .dst_base  (dst_base),
        .len       (len),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .DOut1     (DOut1),
        .DOut2     (DOut2),
        .ADDOut    (ADDOut),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    assign ADDOut = DOut1 + DOut2;

    // Single-port memory: registered read, write on the strobe edge.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] = mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] model_sum(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SAT && s[8]) return 8'hFF;
        return s[7:0];
    endfunction

    task automatic set_mem(input logic [3:0] a, input logic [7:0] v);
        mem[a] = v;
        exm[a] = v;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mem_addr"},  mem_addr,  0);
        check({tag, "_mem_rd"},    mem_rd,    0);
        check({tag, "_mem_wr"},    mem_wr,    0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_dout1"},     DOut1,     0);
        check({tag, "_dout2"},     DOut2,     0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_ovf"},       ovf,       0);
    endtask

    task automatic queue_elem(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [7:0] s;
        rdq.push_back(a);
        rdq.push_back(b);
        s = model_sum(exm[a], exm[b]);
        wrq.push_back({c, s});
        exm[c] = s;
    endtask

    task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] l, input bit poke);
        int cnt;
        int busy_low;
        for (int k = 0; k < int'(l); k++)
            queue_elem(a + 4'(k), b + 4'(k), c + 4'(k));
        @(negedge clk);
        start = 1'b1; src1_base = a; src2_base = b; dst_base = c; len = l;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0;
        busy_low = 0;
        while (cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (done) break;
            if (!busy) busy_low++;
            if (poke) begin
                start = (cnt == 3);
                src1_base = 4'h3; dst_base = 4'h0; len = 4'h5;
            end
        end
        start = 1'b0;
        check("done_latency", cnt, 4 * int'(l) + 1);
        check("busy_during", busy_low, 0);
        check("busy_at_done", busy, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    // Monitor: every memory strobe must match the next expected transaction.
    always @(negedge clk) begin
        if (mem_rd || mem_wr) check("rd_wr_excl", mem_rd & mem_wr, 0);
        if (mem_rd) begin
            if (rdq.size() == 0) begin
                n_chk++;
                $display("FAIL rd_unexpected: read at addr %0h with none expected", mem_addr);
            end else begin
                e_ra = rdq.pop_front();
                check("rd_addr", mem_addr, e_ra);
            end
        end
        if (mem_wr) begin
            if (wrq.size() == 0) begin
                n_chk++;
                $display("FAIL wr_unexpected: write %0d at addr %0h with none expected", mem_wdata, mem_addr);
            end else begin
                e_w = wrq.pop_front();
                check("wr_addr", mem_addr, e_w[11:8]);
                check("wr_data", mem_wdata, e_w[7:0]);
            end
        end
    end

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0;
        src1_base = '0; src2_base = '0; dst_base = '0; len = '0;
        for (int k = 0; k < 16; k++) set_mem(4'(k), 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Basic four-element command
        set_mem(4'h0, 8'd7);  set_mem(4'h1, 8'd3);  set_mem(4'h2, 8'd9);  set_mem(4'h3, 8'd10);
        set_mem(4'h4, 8'd7);  set_mem(4'h5, 8'd1);  set_mem(4'h6, 8'd10); set_mem(4'h7, 8'd10);
        run_cmd(4'h0, 4'h4, 4'h8, 4'd4, 1'b0);
        check("t1_mem8",  mem[8],  14);
        check("t1_mem9",  mem[9],  4);
        check("t1_mem10", mem[10], 19);
        check("t1_mem11", mem[11], 20);

        // Zero-length command
        run_cmd(4'h0, 4'h4, 4'h8, 4'd0, 1'b0);

        // Wrapping addresses with read-after-write through the destination
        set_mem(4'hE, 8'd1); set_mem(4'hF, 8'd2);
        run_cmd(4'hE, 4'h4, 4'hF, 4'd3, 1'b0);
        check("t3_memF", mem[15], 8);
        check("t3_mem0", mem[0],  9);
        check("t3_mem1", mem[1],  19);
        repeat (2) @(negedge clk);
        check("hold_dout1", DOut1, 9);
        check("hold_dout2", DOut2, 10);

        // Start pulsed while busy is ignored
        run_cmd(4'h4, 4'h8, 4'hC, 4'd2, 1'b1);
        check("t4_memC", mem[12], 21);
        check("t4_memD", mem[13], 5);

        // Reset during second element's RD2
        queue_elem(4'h0, 4'h4, 4'h2);
        rdq.push_back(4'h1);
        rdq.push_back(4'h5);
        @(negedge clk);
        start = 1'b1; src1_base = 4'h0; src2_base = 4'h4; dst_base = 4'h2; len = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0;
        while (cnt < 6) begin
            @(negedge clk);
            cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_mem2", mem[2], 16);
        check("t5_mem3", mem[3], 10);
        check("t5_still_idle", busy, 0);

        // Overflowing operands
        set_mem(4'h0, 8'd200); set_mem(4'h1, 8'd100);
        run_cmd(4'h0, 4'h1, 4'h5, 4'd1, 1'b0);
        check("t6_mem5", mem[5], SAT ? 255 : 44);
        check("t6_ovf", ovf, SAT);
        repeat (3) @(negedge clk);
        check("t6_ovf_sticky", ovf, SAT);
        run_cmd(4'h0, 4'h1, 4'h6, 4'd0, 1'b0);
        check("t6_ovf_cleared", ovf, 0);

        repeat (2) @(negedge clk);
        check("rdq_drained", rdq.size(), 0);
        check("wrq_drained", wrq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
